// File: rtl/parking_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl_if
//
// Bundles the lane signals of the parking gate controller.
//   sensor_a   : outer beam, asynchronous, 1 = blocked
//   sensor_b   : inner beam, asynchronous, 1 = blocked
//   is_full    : lot-full status from the occupancy counter
//   is_empty   : lot-empty status from the occupancy counter
//   count_up   : one-cycle pulse per completed entry
//   count_down : one-cycle pulse per completed exit
//   gate_open  : gate actuator, 1 = open
//   full_lamp  : high while an entry is being refused
//   fault      : one-cycle pulse per protocol error or timeout
//
// master drives the sensors/status and observes the controller outputs;
// slave is the controller side.
// ---------------------------------------------------------------------------
interface parking_gate_ctrl_if;
    logic sensor_a;
    logic sensor_b;
    logic is_full;
    logic is_empty;
    logic count_up;
    logic count_down;
    logic gate_open;
    logic full_lamp;
    logic fault;

    modport master (
        output sensor_a,
        output sensor_b,
        output is_full,
        output is_empty,
        input  count_up,
        input  count_down,
        input  gate_open,
        input  full_lamp,
        input  fault
    );

    modport slave (
        input  sensor_a,
        input  sensor_b,
        input  is_full,
        input  is_empty,
        output count_up,
        output count_down,
        output gate_open,
        output full_lamp,
        output fault
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
//
// Two-beam vehicle direction detector and gate controller for a parking lane.
// Each beam is synchronised (2 flops) and debounced; the filtered beams drive
// a transit FSM that opens the gate, refuses entries when the lot is full,
// reports completed entries/exits as counter pulses and flags protocol
// errors or stalled transits with a fault pulse.
//
// Ports
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : parking_gate_ctrl_if.slave (sensors, lot status, outputs)
//
// Parameters
//   DEBOUNCE_CYCLES : 1..15, consecutive differing samples before a filtered
//                     beam changes
//   TIMEOUT_CYCLES  : 2..65535, maximum cycles in any timed (non-idle) state
//
// All outputs are registered. Raw beam to FSM input latency is
// 2 + DEBOUNCE_CYCLES cycles.
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               reset,
    parking_gate_ctrl_if.slave bus
);

    localparam logic [3:0]  DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] DWELL_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ENT_A,
        S_ENT_AB,
        S_ENT_B,
        S_EXT_B,
        S_EXT_BA,
        S_EXT_A,
        S_REJECT,
        S_WAIT_CLR
    } state_t;

    state_t      state;
    logic [15:0] dwell;

    logic        sync_a_p0;
    logic        sync_a_p1;
    logic        sync_b_p0;
    logic        sync_b_p1;
    logic        fa;
    logic        fb;
    logic [3:0]  deb_cnt_a;
    logic [3:0]  deb_cnt_b;

    logic        gate_open_r;
    logic        full_lamp_r;
    logic        count_up_r;
    logic        count_down_r;
    logic        fault_r;

    // Dwell counter saturates so a long stay in IDLE never wraps.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // States that are bounded by the dwell timeout.
    function automatic logic timed_state(input state_t s);
        return (s != S_IDLE) && (s != S_WAIT_CLR);
    endfunction

    // The filtered value flips on the DEBOUNCE_CYCLES-th consecutive
    // differing sample.
    function automatic logic deb_flip(input logic syn, input logic filt,
                                      input logic [3:0] cnt);
        return (syn != filt) && (cnt == DEB_LAST);
    endfunction

    // Any agreeing sample (or a flip) restarts the run length.
    function automatic logic [3:0] deb_next_cnt(input logic syn, input logic filt,
                                                input logic [3:0] cnt);
        return ((syn == filt) || (cnt == DEB_LAST)) ? 4'd0 : cnt + 4'd1;
    endfunction

    // ---- stage p0/p1: two-flop synchronisers, then debounce ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a_p0 <= 1'b0;
            sync_a_p1 <= 1'b0;
            sync_b_p0 <= 1'b0;
            sync_b_p1 <= 1'b0;
            fa        <= 1'b0;
            fb        <= 1'b0;
            deb_cnt_a <= 4'd0;
            deb_cnt_b <= 4'd0;
        end else begin
            sync_a_p0 <= bus.sensor_a;
            sync_a_p1 <= sync_a_p0;
            sync_b_p0 <= bus.sensor_b;
            sync_b_p1 <= sync_b_p0;

            deb_cnt_a <= deb_next_cnt(sync_a_p1, fa, deb_cnt_a);
            deb_cnt_b <= deb_next_cnt(sync_b_p1, fb, deb_cnt_b);
            if (deb_flip(sync_a_p1, fa, deb_cnt_a)) fa <= sync_a_p1;
            if (deb_flip(sync_b_p1, fb, deb_cnt_b)) fb <= sync_b_p1;
        end
    end

    // ---- transit FSM on filtered beams, registered outputs -----------------
    // Pulses default low every cycle; gate/lamp only change on transitions,
    // so they are written only where the state changes. Every transition
    // also clears the dwell counter (the later NBA overrides the increment).
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            dwell        <= 16'd0;
            gate_open_r  <= 1'b0;
            full_lamp_r  <= 1'b0;
            count_up_r   <= 1'b0;
            count_down_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            count_up_r   <= 1'b0;
            count_down_r <= 1'b0;
            fault_r      <= 1'b0;
            dwell        <= sat_inc16(dwell);

            // A stalled transit or refusal wins over any beam change seen in
            // the same cycle, so no state ever exceeds TIMEOUT_CYCLES.
            if (timed_state(state) && (dwell == DWELL_LAST)) begin
                state       <= S_WAIT_CLR;
                dwell       <= 16'd0;
                gate_open_r <= 1'b0;
                full_lamp_r <= 1'b0;
                fault_r     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (fa && fb) begin
                            // Both beams appearing together is not a valid
                            // approach from either side.
                            state   <= S_WAIT_CLR;
                            dwell   <= 16'd0;
                            fault_r <= 1'b1;
                        end else if (fa && !bus.is_full) begin
                            state       <= S_ENT_A;
                            dwell       <= 16'd0;
                            gate_open_r <= 1'b1;
                        end else if (fa) begin
                            state       <= S_REJECT;
                            dwell       <= 16'd0;
                            full_lamp_r <= 1'b1;
                        end else if (fb) begin
                            state       <= S_EXT_B;
                            dwell       <= 16'd0;
                            gate_open_r <= 1'b1;
                        end
                    end

                    S_ENT_A: begin
                        if (fb) begin
                            state <= S_ENT_AB;
                            dwell <= 16'd0;
                        end else if (!fa) begin
                            // Backed out before reaching the inner beam.
                            state       <= S_IDLE;
                            dwell       <= 16'd0;
                            gate_open_r <= 1'b0;
                        end
                    end

                    S_ENT_AB: begin
                        if (!fa && fb) begin
                            state <= S_ENT_B;
                            dwell <= 16'd0;
                        end else if (fa && !fb) begin
                            state <= S_ENT_A;
                            dwell <= 16'd0;
                        end
                    end

                    S_ENT_B: begin
                        if (fa) begin
                            state <= S_ENT_AB;
                            dwell <= 16'd0;
                        end else if (!fb) begin
                            state       <= S_IDLE;
                            dwell       <= 16'd0;
                            gate_open_r <= 1'b0;
                            count_up_r  <= 1'b1;
                        end
                    end

                    S_EXT_B: begin
                        if (fa) begin
                            state <= S_EXT_BA;
                            dwell <= 16'd0;
                        end else if (!fb) begin
                            state       <= S_IDLE;
                            dwell       <= 16'd0;
                            gate_open_r <= 1'b0;
                        end
                    end

                    S_EXT_BA: begin
                        if (fa && !fb) begin
                            state <= S_EXT_A;
                            dwell <= 16'd0;
                        end else if (!fa && fb) begin
                            state <= S_EXT_B;
                            dwell <= 16'd0;
                        end
                    end

                    S_EXT_A: begin
                        if (fb) begin
                            state <= S_EXT_BA;
                            dwell <= 16'd0;
                        end else if (!fa) begin
                            state       <= S_IDLE;
                            dwell       <= 16'd0;
                            gate_open_r <= 1'b0;
                            // An exit from an empty lot means the occupancy
                            // count is wrong; report instead of underflowing.
                            if (bus.is_empty) fault_r      <= 1'b1;
                            else              count_down_r <= 1'b1;
                        end
                    end

                    S_REJECT: begin
                        if (fb) begin
                            // Refused vehicle forced past the closed gate.
                            state       <= S_WAIT_CLR;
                            dwell       <= 16'd0;
                            full_lamp_r <= 1'b0;
                            fault_r     <= 1'b1;
                        end else if (!fa) begin
                            state       <= S_IDLE;
                            dwell       <= 16'd0;
                            full_lamp_r <= 1'b0;
                        end
                    end

                    S_WAIT_CLR: begin
                        if (!fa && !fb) begin
                            state <= S_IDLE;
                            dwell <= 16'd0;
                        end
                    end

                    default: begin
                        state       <= S_IDLE;
                        dwell       <= 16'd0;
                        gate_open_r <= 1'b0;
                        full_lamp_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gate_open  = gate_open_r;
    assign bus.full_lamp  = full_lamp_r;
    assign bus.count_up   = count_up_r;
    assign bus.count_down = count_down_r;
    assign bus.fault      = fault_r;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset;

    parking_gate_ctrl_if bus();

    parking_gate_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    int n_up, n_dn, n_flt;

    // ------------------------------------------------------------------
    // Reference model: beams are delayed two edges through a queue, a
    // filtered beam flips when its last DEB synced samples all disagree
    // with it, and the lane is tracked as a direction (entry/exit) plus
    // how far the vehicle has progressed (1 = first beam only, 2 = both,
    // 3 = second beam only).
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_ENTRY = 1, M_EXIT = 2, M_REJECT = 3, M_WAIT = 4;
    int m_mode, m_pos, m_age;
    bit m_fa, m_fb;
    bit raw_a_q[$], raw_b_q[$];
    bit win_a_q[$], win_b_q[$];
    bit e_gate, e_lamp, e_up, e_dn, e_flt;

    function automatic bit window_flips(input bit win[$], input bit filt);
        if (win.size() < DEB) return 1'b0;
        foreach (win[i]) if (win[i] == filt) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE; m_pos = 0; m_age = 0;
            m_fa = 0; m_fb = 0;
            raw_a_q = '{0, 0}; raw_b_q = '{0, 0};
            win_a_q = {}; win_b_q = {};
            {e_gate, e_lamp, e_up, e_dn, e_flt} = 5'b0;
        end else begin
            int  old_mode, old_pos;
            bit  first, second, syn_a, syn_b;
            old_mode = m_mode; old_pos = m_pos;
            e_up = 0; e_dn = 0; e_flt = 0;

            if (m_mode != M_IDLE && m_mode != M_WAIT && m_age == TMO - 1) begin
                m_mode = M_WAIT; m_pos = 0; e_flt = 1;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (m_fa && m_fb) begin m_mode = M_WAIT; e_flt = 1; end
                        else if (m_fa) begin
                            if (bus.is_full) m_mode = M_REJECT;
                            else begin m_mode = M_ENTRY; m_pos = 1; end
                        end else if (m_fb) begin m_mode = M_EXIT; m_pos = 1; end
                    end
                    M_ENTRY, M_EXIT: begin
                        first  = (m_mode == M_ENTRY) ? m_fa : m_fb;
                        second = (m_mode == M_ENTRY) ? m_fb : m_fa;
                        case (m_pos)
                            1: if (second) m_pos = 2;
                               else if (!first) begin m_mode = M_IDLE; m_pos = 0; end
                            2: if (!first && second) m_pos = 3;
                               else if (first && !second) m_pos = 1;
                            default: if (first) m_pos = 2;
                               else if (!second) begin
                                   if (m_mode == M_ENTRY) e_up = 1;
                                   else if (bus.is_empty) e_flt = 1;
                                   else e_dn = 1;
                                   m_mode = M_IDLE; m_pos = 0;
                               end
                        endcase
                    end
                    M_REJECT: begin
                        if (m_fb) begin m_mode = M_WAIT; e_flt = 1; end
                        else if (!m_fa) m_mode = M_IDLE;
                    end
                    default: if (!m_fa && !m_fb) m_mode = M_IDLE;
                endcase
            end
            if (m_mode != old_mode || m_pos != old_pos) m_age = 0;
            else m_age++;
            e_gate = (m_mode == M_ENTRY) || (m_mode == M_EXIT);
            e_lamp = (m_mode == M_REJECT);

            syn_a = raw_a_q.pop_front(); raw_a_q.push_back(bus.sensor_a);
            syn_b = raw_b_q.pop_front(); raw_b_q.push_back(bus.sensor_b);
            win_a_q.push_back(syn_a); if (win_a_q.size() > DEB) void'(win_a_q.pop_front());
            win_b_q.push_back(syn_b); if (win_b_q.size() > DEB) void'(win_b_q.pop_front());
            if (window_flips(win_a_q, m_fa)) m_fa = !m_fa;
            if (window_flips(win_b_q, m_fb)) m_fb = !m_fb;
        end
    end

    // Cycle-by-cycle comparison against the model, plus pulse tallies.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            logic [4:0] act, req;
            act = {bus.gate_open, bus.full_lamp, bus.count_up, bus.count_down, bus.fault};
            req = {e_gate, e_lamp, e_up, e_dn, e_flt};
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL model_cmp t=%0t actual(gate,lamp,up,dn,flt)=%b required=%b",
                         $time, act, req);
            end
        end
        if (bus.count_up   === 1'b1) n_up++;
        if (bus.count_down === 1'b1) n_dn++;
        if (bus.fault      === 1'b1) n_flt++;
    end

    task automatic check_int(input string name, input int actual, input int req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, req);
        end
    endtask

    typedef struct {
        bit    a, b, full, empty;
        int    hold;
        bit    gate, lamp;
        int    up, dn, flt;
        string name;
    } vec_t;

    // Called at a falling edge; ends at a falling edge.
    task automatic apply_phase(input vec_t v);
        n_up = 0; n_dn = 0; n_flt = 0;
        bus.sensor_a = v.a; bus.sensor_b = v.b;
        bus.is_full  = v.full; bus.is_empty = v.empty;
        repeat (v.hold) @(negedge clk);
        check_int({v.name, ".gate"}, int'(bus.gate_open), int'(v.gate));
        check_int({v.name, ".lamp"}, int'(bus.full_lamp), int'(v.lamp));
        check_int({v.name, ".up"},   n_up,  v.up);
        check_int({v.name, ".dn"},   n_dn,  v.dn);
        check_int({v.name, ".flt"},  n_flt, v.flt);
    endtask

    task automatic check_all_zero(input string name);
        check_int(name, int'({bus.gate_open, bus.full_lamp, bus.count_up,
                              bus.count_down, bus.fault}), 0);
    endtask

    vec_t vecs[$];
    vec_t tail[$];

    initial begin
        //            a  b fu em hold gt lp up dn fl name
        vecs.push_back('{1, 0, 0, 0, 10, 1, 0, 0, 0, 0, "ent_a"});
        vecs.push_back('{1, 1, 0, 0, 10, 1, 0, 0, 0, 0, "ent_ab"});
        vecs.push_back('{0, 1, 0, 0, 10, 1, 0, 0, 0, 0, "ent_b"});
        vecs.push_back('{0, 0, 0, 0, 10, 0, 0, 1, 0, 0, "ent_done"});
        vecs.push_back('{0, 1, 0, 0, 10, 1, 0, 0, 0, 0, "ext_b"});
        vecs.push_back('{1, 1, 0, 0, 10, 1, 0, 0, 0, 0, "ext_ba"});
        vecs.push_back('{1, 0, 0, 0, 10, 1, 0, 0, 0, 0, "ext_a"});
        vecs.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 1, 0, "ext_done"});
        vecs.push_back('{0, 1, 0, 1, 10, 1, 0, 0, 0, 0, "exe_b"});
        vecs.push_back('{1, 1, 0, 1, 10, 1, 0, 0, 0, 0, "exe_ba"});
        vecs.push_back('{1, 0, 0, 1, 10, 1, 0, 0, 0, 0, "exe_a"});
        vecs.push_back('{0, 0, 0, 1, 10, 0, 0, 0, 0, 1, "exe_done"});
        vecs.push_back('{1, 0, 1, 0, 10, 0, 1, 0, 0, 0, "rej_a"});
        vecs.push_back('{0, 0, 1, 0, 10, 0, 0, 0, 0, 0, "rej_clr"});
        vecs.push_back('{1, 0, 0, 0,  2, 0, 0, 0, 0, 0, "glitch_hi"});
        vecs.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, "glitch_lo"});
        vecs.push_back('{1, 0, 0, 0, 100, 0, 0, 0, 0, 1, "timeout"});
        vecs.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, "timeout_clr"});
        vecs.push_back('{1, 0, 1, 0, 10, 0, 1, 0, 0, 0, "rejb_a"});
        vecs.push_back('{1, 1, 1, 0, 10, 0, 0, 0, 0, 1, "rejb_ab"});
        vecs.push_back('{0, 0, 1, 0, 10, 0, 0, 0, 0, 0, "rejb_clr"});
        vecs.push_back('{1, 1, 0, 0, 10, 0, 0, 0, 0, 1, "both"});
        vecs.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, "both_clr"});
        vecs.push_back('{1, 0, 0, 0, 10, 1, 0, 0, 0, 0, "back_a"});
        vecs.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, "back_clr"});
        vecs.push_back('{1, 0, 0, 0, 10, 1, 0, 0, 0, 0, "rst_a"});
        vecs.push_back('{1, 1, 0, 0, 10, 1, 0, 0, 0, 0, "rst_ab"});
        // after the mid-transit reset the car rolls on past the inner beam
        tail.push_back('{0, 1, 0, 0, 10, 1, 0, 0, 0, 0, "post_rst_b"});
        tail.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, "post_rst_clr"});

        reset = 1'b1;
        bus.sensor_a = 0; bus.sensor_b = 0; bus.is_full = 0; bus.is_empty = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        mon_en = 1'b1;
        reset  = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply_phase(vecs[i]);

        // Reset in ENT_AB: everything low on the next cycle, transit dropped.
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_transit_reset");
        reset = 1'b0;
        for (int i = 0; i < tail.size(); i++) apply_phase(tail[i]);

        // Randomised traffic against the model.
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                int hold;
                bus.sensor_a = 1'($urandom_range(0, 1));
                bus.sensor_b = 1'($urandom_range(0, 1));
                bus.is_full  = 1'($urandom_range(0, 1));
                bus.is_empty = 1'($urandom_range(0, 3) == 0);
                hold = ($urandom_range(0, 15) == 0) ? 70 : int'($urandom_range(1, 14));
                repeat (hold) @(negedge clk);
            end
        end
        bus.sensor_a = 0; bus.sensor_b = 0;
        repeat (80) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
